// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register-file slice.
package reg_file_pkg;

  // Default geometry: the datapath's R0-R7 bank of 16-bit registers.
  localparam int unsigned REGF_WIDTH = 16;
  localparam int unsigned REGF_DEPTH = 8;

  // Index width needed to address `depth` registers.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned REGF_AW = addr_w(REGF_DEPTH);

  // Register index for the default 8-entry bank.
  typedef logic [REGF_AW-1:0] regf_addr_t;

endpackage

// File: rtl/reg_file_cell.sv
// One storage register of the bank: synchronous reset beats load.
module reg_cell
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = REGF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout
);

  // Declaration initialiser gives a known power-up value in simulation and on FPGA load.
  logic [WIDTH-1:0] r_q = '0;

  // Reset has priority: a write in the reset cycle is discarded.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_q <= '0;
    else if (Load)
      r_q <= Din;
  end

  assign Dout = r_q;

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one synchronous write port, two independent
// read ports, optional write-to-read bypass and optional registered reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int unsigned WIDTH    = REGF_WIDTH,
  parameter  int unsigned DEPTH    = REGF_DEPTH,
  parameter  bit          BYPASS   = 1'b1,
  parameter  bit          REG_READ = 1'b0,
  localparam int unsigned AW       = addr_w(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    RdAddrA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataA,
  output logic [WIDTH-1:0] RdDataB
);

  logic [WIDTH-1:0] w_mem [DEPTH];
  logic             w_wr_en;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  // A write only lands when reset is not asserted in the same cycle.
  always_comb begin
    w_wr_en = Load && !Reset;
  end

  // Storage: one cell per register, each enabled by its decoded write address.
  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_cell
    reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .Clk   (Clk),
      .Reset (Reset),
      .Load  (Load && (WrAddr == AW'(gi))),
      .Din   (WrData),
      .Dout  (w_mem[gi])
    );
  end

  // Read selection with optional forwarding of the in-flight write data.
  always_comb begin
    w_sel_a = w_mem[RdAddrA];
    w_sel_b = w_mem[RdAddrB];
    if (BYPASS && w_wr_en && (RdAddrA == WrAddr))
      w_sel_a = WrData;
    if (BYPASS && w_wr_en && (RdAddrB == WrAddr))
      w_sel_b = WrData;
  end

  if (REG_READ) begin : g_reg_read
    logic [WIDTH-1:0] r_rd_a = '0;
    logic [WIDTH-1:0] r_rd_b = '0;

    // Capture the selected data each edge; reset forces both outputs to zero.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_rd_a <= '0;
        r_rd_b <= '0;
      end else begin
        r_rd_a <= w_sel_a;
        r_rd_b <= w_sel_b;
      end
    end

    assign RdDataA = r_rd_a;
    assign RdDataB = r_rd_b;
  end else begin : g_comb_read
    assign RdDataA = w_sel_a;
    assign RdDataB = w_sel_b;
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file across its read/bypass modes
// and a wide/deep parameter set.
module tb_reg_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Load;
  logic [2:0]  WrAddr;
  logic [15:0] WrData;
  logic [2:0]  RdAddrA;
  logic [2:0]  RdAddrB;

  logic [15:0] cA, cB, nA, nB, rbA, rbB, rnA, rnB;

  logic        wLoad;
  logic [3:0]  wWrAddr;
  logic [31:0] wWrData;
  logic [3:0]  wRdA;
  logic [3:0]  wRdB;
  logic [31:0] wA, wB;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 Clk = ~Clk;

  // Combinational read, bypass on
  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .REG_READ(1'b0)) u_c (
    .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(cA), .RdDataB(cB));

  // Combinational read, bypass off
  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .REG_READ(1'b0)) u_nb (
    .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(nA), .RdDataB(nB));

  // Registered read, bypass on
  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .REG_READ(1'b1)) u_rb (
    .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(rbA), .RdDataB(rbB));

  // Registered read, bypass off
  reg_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .REG_READ(1'b1)) u_rn (
    .Clk(Clk), .Reset(Reset), .Load(Load), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdDataA(rnA), .RdDataB(rnB));

  // Wide/deep instance
  reg_file #(.WIDTH(32), .DEPTH(16), .BYPASS(1'b1), .REG_READ(1'b0)) u_w (
    .Clk(Clk), .Reset(Reset), .Load(wLoad), .WrAddr(wWrAddr), .WrData(wWrData),
    .RdAddrA(wRdA), .RdAddrB(wRdB), .RdDataA(wA), .RdDataB(wB));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; WrAddr = '0; WrData = '0; RdAddrA = '0; RdAddrB = '0;
    wLoad = 1'b0; wWrAddr = '0; wWrData = '0; wRdA = '0; wRdB = '0;
    edge1();
    chk("rst_rbA", 32'(rbA), 32'h0);
    chk("rst_rbB", 32'(rbB), 32'h0);
    Reset = 1'b0;

    // 1: every register reads zero after reset
    for (int i = 0; i < 8; i++) begin
      RdAddrA = 3'(i);
      RdAddrB = 3'(7 - i);
      #1;
      chk($sformatf("sweep_cA%0d", i), 32'(cA), 32'h0);
      chk($sformatf("sweep_cB%0d", i), 32'(cB), 32'h0);
      edge1();
      chk($sformatf("sweep_rbA%0d", i), 32'(rbA), 32'h0);
      chk($sformatf("sweep_rbB%0d", i), 32'(rbB), 32'h0);
    end

    // 2: two consecutive writes, then read both back
    Load = 1'b1; WrAddr = 3'd3; WrData = 16'hBEEF;
    edge1();
    WrAddr = 3'd5; WrData = 16'h1234;
    edge1();
    Load = 1'b0; RdAddrA = 3'd3; RdAddrB = 3'd5;
    #1;
    chk("wr_cA", 32'(cA), 32'hBEEF);
    chk("wr_cB", 32'(cB), 32'h1234);
    chk("wr_nA", 32'(nA), 32'hBEEF);
    chk("wr_nB", 32'(nB), 32'h1234);
    edge1();
    chk("wr_rbA", 32'(rbA), 32'hBEEF);
    chk("wr_rnB", 32'(rnB), 32'h1234);
    for (int i = 0; i < 8; i++) begin
      if (i != 3 && i != 5) begin
        RdAddrA = 3'(i);
        #1;
        chk($sformatf("others_zero%0d", i), 32'(cA), 32'h0);
      end
    end

    // 3: same-cycle write/read of R2
    Load = 1'b1; WrAddr = 3'd2; WrData = 16'hA5A5; RdAddrA = 3'd2; RdAddrB = 3'd3;
    #1;
    chk("byp_cA", 32'(cA), 32'hA5A5);
    chk("byp_nA", 32'(nA), 32'h0000);
    chk("byp_cB_other", 32'(cB), 32'hBEEF);
    edge1();
    chk("byp_rbA", 32'(rbA), 32'hA5A5);
    chk("byp_rnA", 32'(rnA), 32'h0000);
    Load = 1'b0;
    #1;
    chk("byp_nA_after", 32'(nA), 32'hA5A5);

    // 4: reset and load in the same cycle, reset wins
    Load = 1'b1; WrAddr = 3'd1; WrData = 16'h00FF;
    edge1();
    Load = 1'b0; RdAddrA = 3'd1;
    #1;
    chk("col_pre", 32'(cA), 32'h00FF);
    Reset = 1'b1; Load = 1'b1; WrAddr = 3'd1; WrData = 16'h7777;
    #1;
    chk("col_no_byp", 32'(cA), 32'h00FF);
    edge1();
    Reset = 1'b0; Load = 1'b0;
    #1;
    chk("col_cA", 32'(cA), 32'h0000);
    chk("col_rbA", 32'(rbA), 32'h0000);
    chk("col_cB_R3", 32'(cB), 32'h0000);

    // 5: registered-read latency
    Load = 1'b1; WrAddr = 3'd7; WrData = 16'hCAFE; RdAddrB = 3'd0;
    edge1();
    Load = 1'b0; RdAddrB = 3'd7;
    #1;
    chk("lat_early", 32'(rbB), 32'h0000);
    chk("lat_comb", 32'(cB), 32'hCAFE);
    edge1();
    chk("lat_rbB", 32'(rbB), 32'hCAFE);
    chk("lat_rnB", 32'(rnB), 32'hCAFE);

    // Back-to-back writes to one register: last wins
    Load = 1'b1; WrAddr = 3'd6; WrData = 16'h1111;
    edge1();
    WrData = 16'h2222;
    edge1();
    Load = 1'b0; RdAddrA = 3'd6; RdAddrB = 3'd6;
    #1;
    chk("b2b_A", 32'(cA), 32'h2222);
    chk("b2b_B", 32'(cB), 32'h2222);

    // 6: 32-bit, 16-deep instance
    wLoad = 1'b1; wWrAddr = 4'd15; wWrData = 32'hDEADBEEF;
    edge1();
    wWrAddr = 4'd0; wWrData = 32'h00000001;
    edge1();
    wLoad = 1'b0; wRdA = 4'd15; wRdB = 4'd0;
    #1;
    chk("w_A15", wA, 32'hDEADBEEF);
    chk("w_B0", wB, 32'h00000001);
    wRdA = 4'd15; wRdB = 4'd15;
    #1;
    chk("w_AB15_A", wA, 32'hDEADBEEF);
    chk("w_AB15_B", wB, 32'hDEADBEEF);
    wRdA = 4'd0; wRdB = 4'd7;
    #1;
    chk("w_A0", wA, 32'h00000001);
    chk("w_B7", wB, 32'h00000000);
    wRdA = 4'd14; wRdB = 4'd1;
    #1;
    chk("w_A14", wA, 32'h00000000);
    chk("w_B1", wB, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
